// File: rtl/mic_capture_ctrl.sv
// Mic window capture: waits for a rising mic_on, records a fixed-length window into block RAM,
// then streams it out oldest-first. Optional pre-trigger history is enabled by MIC_CAP_PRETRIG_EN.
module mic_capture_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int PRE_SAMPLES = 64,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              mic_on,
    input  logic [ADDR_W:0]   cap_len,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              capture_done,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   TWO     = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    if (DEPTH < 4 || PRE_SAMPLES >= DEPTH || (1 << ADDR_W) != DEPTH) begin : g_bad_params
        $error("mic_capture_ctrl: DEPTH must be a power of two >= 4 and PRE_SAMPLES < DEPTH");
    end

    state_t            state_reg;
    logic              mic_s1_reg, mic_s2_reg, mic_prev_reg;
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg, start_ptr_reg;
    logic [ADDR_W:0]   len_reg, cnt_reg, remaining_reg;
    logic              prime_reg, out_valid_reg, out_last_reg, busy_reg, done_reg;
    logic [15:0]       drop_cnt_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    logic              mic_rise, wr_en, accept;
    logic [ADDR_W-1:0] wr_ptr_next, rd_addr;
    logic [ADDR_W:0]   len_eff;

    assign mic_rise    = mic_s2_reg & ~mic_prev_reg;
    assign accept      = (state_reg == DRAIN) && out_valid_reg && out_ready;
    assign wr_ptr_next = wr_en ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    // Re-reading the current address while stalled keeps rd_q (and thus out_data) stable.
    assign rd_addr     = accept ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

`ifdef MIC_CAP_PRETRIG_EN
    localparam logic [ADDR_W:0] PRE_W   = (ADDR_W+1)'(PRE_SAMPLES);
    localparam logic [ADDR_W:0] WIN_MAX = (ADDR_W+1)'(DEPTH - PRE_SAMPLES);

    logic [ADDR_W:0] fill_reg, fill_next;

    assign wr_en     = sample_valid && (state_reg == CAPTURE || state_reg == IDLE);
    assign fill_next = (sample_valid && fill_reg != PRE_W) ? fill_reg + ONE : fill_reg;
`else
    assign wr_en = sample_valid && (state_reg == CAPTURE);
`endif

    always_comb begin
        len_eff = cap_len;
        if (cap_len == '0 || cap_len > DEPTH_W)
            len_eff = DEPTH_W;
`ifdef MIC_CAP_PRETRIG_EN
        if (len_eff > WIN_MAX)
            len_eff = WIN_MAX;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[wr_ptr_reg] <= sample_data;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mic_s1_reg    <= 1'b0;
            mic_s2_reg    <= 1'b0;
            mic_prev_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            start_ptr_reg <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            remaining_reg <= '0;
            prime_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            drop_cnt_reg  <= '0;
`ifdef MIC_CAP_PRETRIG_EN
            fill_reg      <= '0;
`endif
        end else begin
            mic_s1_reg   <= mic_on;
            mic_s2_reg   <= mic_s1_reg;
            mic_prev_reg <= mic_s2_reg;
            done_reg     <= 1'b0;
            wr_ptr_reg   <= wr_ptr_next;
            case (state_reg)
                IDLE: begin
`ifdef MIC_CAP_PRETRIG_EN
                    fill_reg <= fill_next;
`endif
                    if (mic_rise) begin
                        state_reg <= CAPTURE;
                        busy_reg  <= 1'b1;
                        len_reg   <= len_eff;
                        cnt_reg   <= '0;
`ifdef MIC_CAP_PRETRIG_EN
                        start_ptr_reg <= wr_ptr_next - fill_next[ADDR_W-1:0];
                        remaining_reg <= len_eff + fill_next;
`else
                        start_ptr_reg <= wr_ptr_reg;
                        remaining_reg <= len_eff;
`endif
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        cnt_reg <= cnt_reg + ONE;
                        if (cnt_reg + ONE == len_reg) begin
                            state_reg  <= DRAIN;
                            done_reg   <= 1'b1;
                            rd_ptr_reg <= start_ptr_reg;
                            prime_reg  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (sample_valid && drop_cnt_reg != 16'hFFFF)
                        drop_cnt_reg <= drop_cnt_reg + 16'd1;
                    // One idle cycle lets the first RAM read land before out_valid rises.
                    if (!out_valid_reg) begin
                        if (prime_reg) begin
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (remaining_reg == ONE);
                        end else begin
                            prime_reg <= 1'b1;
                        end
                    end else if (out_ready) begin
                        rd_ptr_reg    <= rd_addr;
                        remaining_reg <= remaining_reg - ONE;
                        out_last_reg  <= (remaining_reg == TWO);
                        if (remaining_reg == ONE) begin
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
`ifdef MIC_CAP_PRETRIG_EN
                            fill_reg      <= '0;
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_valid_reg ? rd_q : '0;
    assign out_last     = out_last_reg;
    assign busy         = busy_reg;
    assign capture_done = done_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl at DEPTH=16: table of capture windows plus hand-written
// sequences for retrigger/drop, mid-capture reset and (with MIC_CAP_PRETRIG_EN) pre-trigger history.
module tb_mic_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int ADDR_W = 4;
`ifdef MIC_CAP_PRETRIG_EN
    localparam int FULL = DEPTH - PRE;
`else
    localparam int FULL = DEPTH;
`endif

    logic              clk_in = 1'b0;
    logic              reset = 1'b0;
    logic              mic_on = 1'b0;
    logic [ADDR_W:0]   cap_len = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              capture_done;
    logic [15:0]       drop_cnt;

    int errors = 0;
    int checks = 0;
    int cd_count = 0;
    int exp_q[$];

    typedef struct {
        logic [ADDR_W:0] cap_len;
        int              nsamp;
        int              base;
        bit              stall;
        int              exp_words;
        int              exp_last;
    } vec_t;

    vec_t vecs[4];

    mic_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_SAMPLES(PRE)) dut (
        .clk_in(clk_in), .reset(reset), .mic_on(mic_on), .cap_len(cap_len),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .capture_done(capture_done), .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (capture_done) cd_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_trigger(input logic [ADDR_W:0] len);
        @(negedge clk_in);
        mic_on  = 1'b0;
        cap_len = len;
        repeat (3) @(negedge clk_in);
        mic_on = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic send_samples(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'(base + i);
            @(negedge clk_in);
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!capture_done && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        check({name, " capture_done seen"}, capture_done, 1);
        @(negedge clk_in);
        check({name, " capture_done one cycle"}, capture_done, 0);
        check({name, " out_valid +1"}, out_valid, 0);
        @(negedge clk_in);
        check({name, " out_valid +2"}, out_valid, 1);
    endtask

    task automatic drain(input bit stall, input string name);
        int got = 0;
        int cyc = 0;
        int first = -1;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        while (got < exp_q.size() && cyc < 400) begin
            if (stalled) begin
                check({name, " hold valid"}, out_valid, 1);
                check({name, " hold data"}, out_data, held);
                stalled = 1'b0;
            end
            out_ready = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    check({name, " data"}, out_data, exp_q[got]);
                    check({name, " last"}, out_last, got == exp_q.size() - 1);
                    $display("%s word %0d data=%0d last=%0b", name, got, out_data, out_last);
                    got++;
                end else begin
                    held    = out_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk_in);
            cyc++;
        end
        out_ready = 1'b0;
        check({name, " word count"}, got, exp_q.size());
        if (!stall) check({name, " throughput cycles"}, cyc - first, exp_q.size());
        check({name, " out_valid after"}, out_valid, 0);
        check({name, " busy after"}, busy, 0);
    endtask

    task automatic fill_exp(input int n, input int base);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + i);
    endtask

    initial begin
        int c0;
        vecs[0] = '{cap_len: 5'd8,  nsamp: 8,    base: 0, stall: 1'b0, exp_words: 8,    exp_last: 7};
        vecs[1] = '{cap_len: 5'd8,  nsamp: 8,    base: 0, stall: 1'b1, exp_words: 8,    exp_last: 7};
        vecs[2] = '{cap_len: 5'd0,  nsamp: FULL, base: 0, stall: 1'b0, exp_words: FULL, exp_last: FULL-1};
        vecs[3] = '{cap_len: 5'd20, nsamp: FULL, base: 0, stall: 1'b0, exp_words: FULL, exp_last: FULL-1};

        // Reset state
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset busy", busy, 0);
        check("reset capture_done", capture_done, 0);
        check("reset drop_cnt", drop_cnt, 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            c0 = cd_count;
            do_trigger(vecs[v].cap_len);
            check($sformatf("vec%0d busy after trigger", v), busy, 1);
            send_samples(vecs[v].nsamp, vecs[v].base);
            wait_done($sformatf("vec%0d", v));
            fill_exp(vecs[v].exp_words, vecs[v].base);
            check($sformatf("vec%0d expected last", v), exp_q[exp_q.size()-1], vecs[v].exp_last);
            drain(vecs[v].stall, $sformatf("vec%0d", v));
            check($sformatf("vec%0d capture_done pulses", v), cd_count - c0, 1);
        end

        // mic_on toggling during CAPTURE, strobes during DRAIN
        c0 = cd_count;
        do_trigger(5'd8);
        send_samples(4, 40);
        mic_on = 1'b0;
        repeat (4) @(negedge clk_in);
        mic_on = 1'b1;
        repeat (4) @(negedge clk_in);
        send_samples(4, 44);
        wait_done("retrig");
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'hDEAD;
            @(negedge clk_in);
        end
        sample_valid = 1'b0;
        @(negedge clk_in);
        check("retrig drop_cnt", drop_cnt, 5);
        check("retrig stalled head", out_data, 40);
        fill_exp(8, 40);
        drain(1'b0, "retrig");
        check("retrig capture_done pulses", cd_count - c0, 1);
        repeat (10) @(negedge clk_in);
        check("stale mic_on no trigger", busy, 0);
        do_trigger(5'd4);
        send_samples(4, 60);
        wait_done("second");
        fill_exp(4, 60);
        drain(1'b0, "second");

        // Reset mid-capture
        do_trigger(5'd8);
        send_samples(3, 30);
        reset = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst out_last", out_last, 0);
        check("midrst busy", busy, 0);
        check("midrst capture_done", capture_done, 0);
        check("midrst drop_cnt", drop_cnt, 0);
        mic_on = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        do_trigger(5'd8);
        send_samples(8, 10);
        wait_done("postrst");
        fill_exp(8, 10);
        drain(1'b1, "postrst");

`ifdef MIC_CAP_PRETRIG_EN
        // Pre-trigger history: 10 idle samples, keep last 4
        mic_on  = 1'b0;
        cap_len = 5'd3;
        repeat (4) @(negedge clk_in);
        send_samples(10, 100);
        mic_on = 1'b1;
        repeat (4) @(negedge clk_in);
        send_samples(3, 200);
        wait_done("pretrig");
        exp_q = '{106, 107, 108, 109, 200, 201, 202};
        drain(1'b0, "pretrig");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
